encoder_16_to_4_arbiter: RTL and testbench
==========================================

// Module: encoder_16_to_4_arbiter
// PURPOSE
//   Registered 16-to-4 encoder with arbitration: turns 16 one-bit request lines into a
//   4-bit source code plus valid. Sits on the Mini-SRC internal bus as the bus-driver
//   select generator and feeds the bus mux select. Holds a grant until release.
//   Rotating (round-robin) priority prevents starvation.
// PARAMETERS
//   ROUND_ROBIN   1   1: priority rotates past the last grantee; 0: fixed, lowest index wins
//   AUTO_RELEASE  1   1: grant also ends when the granted request bit drops; 0: only in_release ends it
// PORTS
//   clk          input   1   rising-edge clock, the only clock
//   reset        input   1   synchronous, active-high reset
//   in_enable    input   1   arbitration enable; low aborts any grant
//   in_16        input   16  request lines, bit i = source i requests the bus
//   in_release   input   1   grantee done; ends the current grant
//   out_4        output  4   encoded index of granted source (valid only with out_valid)
//   out_valid    output  1   grant active
//   out_multi    output  1   registered: >1 request bit was set at grant time
// BEHAVIOUR
//   - Reset (sampled at clk edge): state=IDLE, out_4=0, out_valid=0, out_multi=0, ptr=0.
//   - All outputs are registered; no combinational input-to-output path.
//   - States: IDLE, GRANT.
//   - IDLE:
//       in_enable=1 and in_16!=0 -> pick the winner, load out_4=winner, out_valid=1,
//       out_multi=(popcount(in_16)>1), go GRANT. Latency: request to out_valid = 1 clk.
//       Otherwise stay IDLE with out_valid=0.
//   - Winner selection:
//       ROUND_ROBIN=1: first set bit scanning ptr, ptr+1, ... 15, 0, ... ptr-1 (mod 16).
//       ROUND_ROBIN=0: lowest set index; ptr is ignored.
//   - GRANT: out_4 and out_multi are frozen; changes on in_16 never switch the grantee.
//       The grant ends when any of the following holds:
//       * in_release=1;
//       * AUTO_RELEASE=1 and in_16[out_4]=0;
//       * in_enable=0.
//       On end: out_valid=0 next clk, go IDLE. On a normal end (release or drop),
//       ptr=(out_4+1) mod 16 with 4-bit wrap, so 15 -> 0. An in_enable abort leaves ptr unchanged.
//   - Simultaneous in_release and in_enable=0: treated as an abort; ptr is unchanged.
//   - Back-to-back grants need at least one IDLE cycle. The bus is never re-granted in the
//     cycle its release is seen, so there is no driver overlap.
//   - in_release in IDLE is ignored. in_16=0 in IDLE keeps out_valid=0; out_4 keeps its last value.
//   - Reset mid-grant: next clk all outputs are at reset values and ptr=0, regardless of other inputs.
//   - out_4 is always a legal code 0..15; no undefined or X encodings.
// TESTING
//   1. Reset, in_enable=1, in_16=16'h0020 -> 1 clk later out_valid=1, out_4=5, out_multi=0.
//   2. Round robin: in_16=16'h8001 held, pulse in_release after each grant ->
//      grants alternate 0,15,0,15; out_multi=1 on each grant.
//   3. Wrap: grant 15, release; then in_16=16'h8004 -> next grant is 2 (ptr wrapped to 0);
//      with ROUND_ROBIN=0 the grant is 2 as well.
//   4. Hold: grant 3 with in_16=16'h0008; change in_16 to 16'h0009 -> out_4 stays 3 until release.
//   5. Drop/abort: AUTO_RELEASE=1, clear bit 3 while granted -> out_valid=0 next clk.
//      Separately, in_enable=0 mid-grant -> out_valid=0 and the next grant order is unchanged.
//   6. Reset mid-grant: assert reset while out_valid=1, out_4=9 -> next clk out_valid=0,
//      out_4=0, out_multi=0; a following in_16=16'hFFFF grants 0.

Source files
------------

// File: rtl/encoder_16_to_4_arbiter.sv
// ----------------------------------------------------------------------------
// encoder_16_to_4_arbiter
//
// Registered 16-to-4 encoder with arbitration. It turns 16 one-bit request
// lines into a 4-bit source code plus a valid flag and drives the bus-driver
// select of the internal bus. Once a grant is issued, the grantee keeps the
// bus until it releases it. Rotating priority prevents any source from being
// starved.
//
// Parameters
//   ROUND_ROBIN  : 1 -> the search starts just past the last normal grantee;
//                  0 -> fixed priority, where the lowest set index wins.
//   AUTO_RELEASE : 1 -> a grant also ends when the granted request bit drops;
//                  0 -> only in_release (or disable) ends a grant.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   in_enable  in   1   arbitration enable; low aborts any grant
//   in_16      in  16   request lines, bit i = source i wants the bus
//   in_release in   1   grantee done; ends the current grant
//   out_4      out  4   encoded index of the granted source
//   out_valid  out  1   grant active
//   out_multi  out  1   more than one request was pending at grant time
// ----------------------------------------------------------------------------
module encoder_16_to_4_arbiter #(
  parameter int ROUND_ROBIN  = 1,
  parameter int AUTO_RELEASE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_enable,
  input  logic [15:0] in_16,
  input  logic        in_release,
  output logic [3:0]  out_4,
  output logic        out_valid,
  output logic        out_multi
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Finds the first set request, scanning upward from start and wrapping
  // past 15 back to 0. The 4-bit index arithmetic performs the wrap.
  // Returns start when no bit is set; callers only use the result when a
  // request is present.
  function automatic logic [3:0] pick_winner(input logic [15:0] req,
                                             input logic [3:0]  start);
    logic [3:0] idx;
    logic       found;
    logic [3:0] win;
    win   = start;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = start + 4'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // A vector has more than one bit set exactly when clearing its lowest
  // set bit leaves something behind.
  function automatic logic more_than_one(input logic [15:0] req);
    return (req & (req - 16'd1)) != 16'd0;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  out_4_q, out_4_d;
  logic        out_valid_q, out_valid_d;
  logic        out_multi_q, out_multi_d;
  logic [3:0]  ptr_q, ptr_d;

  logic        req_any_s;
  logic [3:0]  start_s;
  logic [3:0]  winner_s;
  logic        multi_s;
  logic        drop_s;

  // Request decode. This path only feeds next-state logic, never an output.
  always_comb begin
    req_any_s = (in_16 != 16'd0);
    if (ROUND_ROBIN != 0) begin
      start_s = ptr_q;
    end else begin
      start_s = 4'd0;
    end
    winner_s = pick_winner(in_16, start_s);
    multi_s  = more_than_one(in_16);
    if (AUTO_RELEASE != 0) begin
      drop_s = ~in_16[out_4_q];
    end else begin
      drop_s = 1'b0;
    end
  end

  // Next-state and output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d     = state_q;
    out_4_d     = out_4_q;
    out_valid_d = out_valid_q;
    out_multi_d = out_multi_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        if (in_enable && req_any_s) begin
          state_d     = GRANT;
          out_4_d     = winner_s;
          out_valid_d = 1'b1;
          out_multi_d = multi_s;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      GRANT: begin
        // Disable wins over release: it is an abort, so the rotation
        // pointer must stay where it was.
        if (!in_enable) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (in_release || drop_s) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          ptr_d       = out_4_q + 4'd1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_4_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_multi_q <= 1'b0;
      ptr_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      out_4_q     <= out_4_d;
      out_valid_q <= out_valid_d;
      out_multi_q <= out_multi_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_4     = out_4_q;
  assign out_valid = out_valid_q;
  assign out_multi = out_multi_q;

endmodule

// File: tb/tb_encoder_16_to_4_arbiter.sv
// ----------------------------------------------------------------------------
// tb_encoder_16_to_4_arbiter
//
// Drives two arbiters with the same inputs. Instance A uses rotating
// priority with auto-release, and instance B uses fixed priority with
// explicit release only. Directed scenarios compare against hand-derived
// constants. A randomized phase compares against a behavioural model of the
// grant rules.
// ----------------------------------------------------------------------------
module tb_encoder_16_to_4_arbiter;

  logic        clk;
  logic        reset;
  logic        in_enable;
  logic [15:0] in_16;
  logic        in_release;
  logic [3:0]  a_out_4, b_out_4;
  logic        a_valid, b_valid;
  logic        a_multi, b_multi;

  int errors = 0;
  int checks = 0;

  // Model state per instance: index 0 = A, index 1 = B.
  int m_valid [2];
  int m_idx   [2];
  int m_multi [2];
  int m_ptr   [2];
  int m_rr    [2] = '{1, 0};
  int m_ar    [2] = '{1, 0};

  encoder_16_to_4_arbiter #(.ROUND_ROBIN(1), .AUTO_RELEASE(1)) dut_a (
    .clk(clk), .reset(reset), .in_enable(in_enable), .in_16(in_16),
    .in_release(in_release), .out_4(a_out_4), .out_valid(a_valid),
    .out_multi(a_multi)
  );

  encoder_16_to_4_arbiter #(.ROUND_ROBIN(0), .AUTO_RELEASE(0)) dut_b (
    .clk(clk), .reset(reset), .in_enable(in_enable), .in_16(in_16),
    .in_release(in_release), .out_4(b_out_4), .out_valid(b_valid),
    .out_multi(b_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advances the model by one clock, using the inputs present at the edge.
  task automatic model_step();
    int cnt;
    int start;
    int idx;
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        m_valid[n] = 0; m_idx[n] = 0; m_multi[n] = 0; m_ptr[n] = 0;
      end else if (m_valid[n] == 0) begin
        if (in_enable && in_16 != 16'd0) begin
          cnt = 0;
          for (int b = 0; b < 16; b++) cnt += int'(in_16[b]);
          start = (m_rr[n] != 0) ? m_ptr[n] : 0;
          for (int k = 15; k >= 0; k--) begin
            idx = (start + k) % 16;
            if (in_16[idx]) m_idx[n] = idx;
          end
          m_valid[n] = 1;
          m_multi[n] = (cnt > 1) ? 1 : 0;
        end
      end else begin
        if (!in_enable) begin
          m_valid[n] = 0;
        end else if (in_release || (m_ar[n] != 0 && in_16[m_idx[n]] == 1'b0)) begin
          m_valid[n] = 0;
          m_ptr[n]   = (m_idx[n] + 1) % 16;
        end
      end
    end
  endtask

  // One clock: edge, model update, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_enable = 1'b0; in_16 = 16'd0; in_release = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_valid, a_out_4, a_multi} !== 6'b0_0000_0) begin
      errors++; $display("FAIL reset_a: got %b want %b", {a_valid, a_out_4, a_multi}, 6'b0_0000_0);
    end
    checks++;
    if ({b_valid, b_out_4, b_multi} !== 6'b0_0000_0) begin
      errors++; $display("FAIL reset_b: got %b want %b", {b_valid, b_out_4, b_multi}, 6'b0_0000_0);
    end
  endtask

  task automatic test_single();
    in_enable = 1'b1; in_16 = 16'h0020;
    tick();
    checks++;
    if ({a_valid, a_out_4, a_multi} !== {1'b1, 4'd5, 1'b0}) begin
      errors++; $display("FAIL single_a: got %b want %b", {a_valid, a_out_4, a_multi}, {1'b1, 4'd5, 1'b0});
    end
    checks++;
    if ({b_valid, b_out_4, b_multi} !== {1'b1, 4'd5, 1'b0}) begin
      errors++; $display("FAIL single_b: got %b want %b", {b_valid, b_out_4, b_multi}, {1'b1, 4'd5, 1'b0});
    end
    in_release = 1'b1;
    tick();
    in_release = 1'b0;
    checks++;
    if ({a_valid, b_valid} !== 2'b00) begin
      errors++; $display("FAIL single_release: got %b want %b", {a_valid, b_valid}, 2'b00);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a;
    do_reset();
    in_enable = 1'b1; in_16 = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0) ? 4'd0 : 4'd15;
      tick();
      checks++;
      if ({a_valid, a_out_4, a_multi} !== {1'b1, exp_a, 1'b1}) begin
        errors++; $display("FAIL rr_a[%0d]: got %b want %b", i, {a_valid, a_out_4, a_multi}, {1'b1, exp_a, 1'b1});
      end
      checks++;
      if ({b_valid, b_out_4, b_multi} !== {1'b1, 4'd0, 1'b1}) begin
        errors++; $display("FAIL rr_b[%0d]: got %b want %b", i, {b_valid, b_out_4, b_multi}, {1'b1, 4'd0, 1'b1});
      end
      in_release = 1'b1;
      tick();
      in_release = 1'b0;
      checks++;
      if ({a_valid, b_valid} !== 2'b00) begin
        errors++; $display("FAIL rr_gap[%0d]: got %b want %b", i, {a_valid, b_valid}, 2'b00);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    in_enable = 1'b1; in_16 = 16'h8000;
    tick();
    checks++;
    if ({a_out_4, b_out_4} !== {4'd15, 4'd15}) begin
      errors++; $display("FAIL wrap_first: got %h want %h", {a_out_4, b_out_4}, 8'hFF);
    end
    in_release = 1'b1;
    tick();
    in_release = 1'b0; in_16 = 16'h8004;
    tick();
    checks++;
    if ({a_valid, a_out_4, b_valid, b_out_4} !== {1'b1, 4'd2, 1'b1, 4'd2}) begin
      errors++; $display("FAIL wrap_second: got %b want %b", {a_valid, a_out_4, b_valid, b_out_4}, {1'b1, 4'd2, 1'b1, 4'd2});
    end
    in_release = 1'b1;
    tick();
    in_release = 1'b0;
  endtask

  task automatic test_hold();
    in_enable = 1'b1; in_16 = 16'h0008;
    tick();
    in_16 = 16'h0009;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({a_valid, a_out_4, a_multi, b_valid, b_out_4, b_multi} !== {1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b0}) begin
        errors++; $display("FAIL hold[%0d]: got %b want %b", i, {a_valid, a_out_4, a_multi, b_valid, b_out_4, b_multi}, {1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b0});
      end
    end
    in_release = 1'b1;
    tick();
    in_release = 1'b0; in_16 = 16'h0000;
    checks++;
    if ({a_valid, a_out_4, b_valid, b_out_4} !== {1'b0, 4'd3, 1'b0, 4'd3}) begin
      errors++; $display("FAIL hold_release: got %b want %b", {a_valid, a_out_4, b_valid, b_out_4}, {1'b0, 4'd3, 1'b0, 4'd3});
    end
  endtask

  task automatic test_drop_abort();
    in_enable = 1'b1; in_16 = 16'h0008;
    tick();
    in_16 = 16'h0000;
    tick();
    checks++;
    if ({a_valid, b_valid, b_out_4} !== {1'b0, 1'b1, 4'd3}) begin
      errors++; $display("FAIL drop: got %b want %b", {a_valid, b_valid, b_out_4}, {1'b0, 1'b1, 4'd3});
    end
    in_release = 1'b1;
    tick();
    in_release = 1'b0;
    // Abort: the pointer must not move, so 16'h0003 keeps granting 0 on A.
    do_reset();
    in_enable = 1'b1; in_16 = 16'h0003;
    tick();
    in_enable = 1'b0;
    tick();
    checks++;
    if ({a_valid, b_valid} !== 2'b00) begin
      errors++; $display("FAIL abort: got %b want %b", {a_valid, b_valid}, 2'b00);
    end
    in_enable = 1'b1;
    tick();
    checks++;
    if ({a_valid, a_out_4} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL abort_order: got %b want %b", {a_valid, a_out_4}, {1'b1, 4'd0});
    end
    in_release = 1'b1; in_enable = 1'b0;
    tick();
    in_release = 1'b0; in_enable = 1'b1;
    tick();
    checks++;
    if ({a_valid, a_out_4} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL abort_release_order: got %b want %b", {a_valid, a_out_4}, {1'b1, 4'd0});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_enable = 1'b1; in_16 = 16'h0200;
    tick();
    checks++;
    if ({a_valid, a_out_4} !== {1'b1, 4'd9}) begin
      errors++; $display("FAIL mid_grant: got %b want %b", {a_valid, a_out_4}, {1'b1, 4'd9});
    end
    reset = 1'b1; in_16 = 16'hFFFF;
    tick();
    reset = 1'b0;
    checks++;
    if ({a_valid, a_out_4, a_multi, b_valid, b_out_4, b_multi} !== 12'd0) begin
      errors++; $display("FAIL mid_reset: got %b want %b", {a_valid, a_out_4, a_multi, b_valid, b_out_4, b_multi}, 12'd0);
    end
    tick();
    checks++;
    if ({a_valid, a_out_4, a_multi, b_valid, b_out_4, b_multi} !== {1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1}) begin
      errors++; $display("FAIL mid_regrant: got %b want %b", {a_valid, a_out_4, a_multi, b_valid, b_out_4, b_multi}, {1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1});
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(63) == 0);
      in_enable  = ($urandom_range(7) != 0);
      in_release = ($urandom_range(3) == 0);
      r = $urandom_range(3);
      case (r)
        0: in_16 = 16'd0;
        1: in_16 = 16'd1 << $urandom_range(15);
        2: in_16 = 16'($urandom & $urandom);
        default: in_16 = in_16;
      endcase
      tick();
      checks++;
      if ({a_valid, a_out_4, a_multi} !== {m_valid[0] != 0, 4'(m_idx[0]), m_multi[0] != 0}) begin
        errors++; $display("FAIL rand_a[%0d]: got %b want %b", i, {a_valid, a_out_4, a_multi}, {m_valid[0] != 0, 4'(m_idx[0]), m_multi[0] != 0});
      end
      checks++;
      if ({b_valid, b_out_4, b_multi} !== {m_valid[1] != 0, 4'(m_idx[1]), m_multi[1] != 0}) begin
        errors++; $display("FAIL rand_b[%0d]: got %b want %b", i, {b_valid, b_out_4, b_multi}, {m_valid[1] != 0, 4'(m_idx[1]), m_multi[1] != 0});
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_enable = 1'b0; in_16 = 16'd0; in_release = 1'b0;
    for (int n = 0; n < 2; n++) begin
      m_valid[n] = 0; m_idx[n] = 0; m_multi[n] = 0; m_ptr[n] = 0;
    end
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_hold();
    test_drop_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
